// File: rtl/four_and_pkg.sv
// Shared types, constants and the golden reference for the FourAnd sweeper.
package four_and_pkg;

    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned VEC_W       = 4;
    localparam int unsigned ERR_W       = 5;
    localparam int unsigned HOLD_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_e;

    typedef struct packed {
        logic e;
        logic f;
        logic g;
    } efg_t;

    // Expected FourAnd response; vec bit 0 is a, bit 3 is d.
    function automatic efg_t four_and_golden(input logic [VEC_W-1:0] vec);
        efg_t r;
        r.e = vec[0] & vec[1];
        r.f = vec[2] & vec[3];
        r.g = &vec;
        return r;
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Per-vector hold counter; o_last_c flags the final cycle of each hold.
module sweep_hold_timer
    import four_and_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_last_c
);

    logic [HOLD_W-1:0] r_hold;

    assign o_last_c = (r_hold == HOLD_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (i_clr) begin
            r_hold <= '0;
        end else if (o_last_c) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end

endmodule

// File: rtl/four_and_sweeper.sv
// Drives all 16 FourAnd input vectors, checks e/f/g against the golden
// function at the end of each hold, and reports a pass/fail summary.
module four_and_sweeper
    import four_and_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] fail_vec
);

    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("four_and_sweeper: HOLD_CYCLES must be within 2..255");
    end

    sweep_state_e     r_state;
    sweep_state_e     w_state_nxt;
    logic [VEC_W-1:0] r_vec;
    logic [VEC_W-1:0] w_vec_nxt;
    logic [ERR_W-1:0] r_err_cnt;
    logic [ERR_W-1:0] w_err_nxt;
    logic [VEC_W-1:0] r_fail_vec;
    logic [VEC_W-1:0] w_fail_nxt;
    logic             r_first_seen;
    logic             w_first_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic             w_last_c;
    logic             w_timer_clr;
    logic             w_mismatch;
    efg_t             w_golden;
    efg_t             w_observed;

    assign w_timer_clr = (r_state != RUN);

    sweep_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_timer_clr),
        .o_last_c (w_last_c)
    );

    assign w_golden   = four_and_golden(r_vec);
    assign w_observed = {e, f, g};
    assign w_mismatch = (w_observed != w_golden);

    // Next-state, vector advance and result accumulation.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_err_nxt   = r_err_cnt;
        w_fail_nxt  = r_fail_vec;
        w_first_nxt = r_first_seen;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_vec_nxt   = '0;
                    w_err_nxt   = '0;
                    w_fail_nxt  = '0;
                    w_first_nxt = 1'b0;
                end
            end
            RUN: begin
                if (w_last_c) begin
                    if (w_mismatch) begin
                        if (r_err_cnt != ERR_W'(NUM_VECTORS)) begin
                            w_err_nxt = r_err_cnt + ERR_W'(1);
                        end
                        if (!r_first_seen) begin
                            w_fail_nxt  = r_vec;
                            w_first_nxt = 1'b1;
                        end
                    end
                    if (r_vec == VEC_W'(NUM_VECTORS - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_vec_nxt = r_vec + VEC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
        w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_vec        <= '0;
            r_err_cnt    <= '0;
            r_fail_vec   <= '0;
            r_first_seen <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vec        <= w_vec_nxt;
            r_err_cnt    <= w_err_nxt;
            r_fail_vec   <= w_fail_nxt;
            r_first_seen <= w_first_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
        end
    end

    assign a        = r_vec[0];
    assign b        = r_vec[1];
    assign c        = r_vec[2];
    assign d        = r_vec[3];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_vec = r_fail_vec;

endmodule

// File: tb/tb_four_and_sweeper.sv
// Bench for four_and_sweeper: two instances (HOLD_CYCLES 4 and 2) driving a
// behavioural FourAnd with selectable faults, checked against a sweep model.
module tb_four_and_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fault    = 0;   // 0: good, 1: g stuck at 0, 2: e = a|b

    logic [1:0] rst_t;
    logic [1:0] start_t;
    logic [1:0] a, b, c, d, e, f, g;
    logic [1:0] busy, done, pass;
    logic [4:0] err[2];
    logic [3:0] fv[2];

    int m_phase[2];   // 0 idle, 1 sweeping, 2 finished
    int m_t[2];       // cycles since the sweep started
    int m_flt[2];     // fault mode in force for the current sweep

    function automatic logic [2:0] golden(input int v);
        logic [2:0] r;
        r[2] = ((v % 4) == 3);
        r[1] = ((v / 4) == 3);
        r[0] = (v == 15);
        return r;
    endfunction

    function automatic logic [2:0] four_and_model(input int v, input int flt);
        logic [2:0] r;
        r = golden(v);
        if (flt == 1) r[0] = 1'b0;
        if (flt == 2) r[2] = ((v % 4) != 0);
        return r;
    endfunction

    function automatic int exp_err(input int nvec, input int flt);
        int cnt;
        cnt = 0;
        for (int v = 0; v < nvec; v++)
            if (four_and_model(v, flt) != golden(v)) cnt++;
        return cnt;
    endfunction

    function automatic int exp_fail(input int nvec, input int flt);
        for (int v = 0; v < nvec; v++)
            if (four_and_model(v, flt) != golden(v)) return v;
        return 0;
    endfunction

    function automatic int hold_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    assign {e[0], f[0], g[0]} = four_and_model(int'({d[0], c[0], b[0], a[0]}), fault);
    assign {e[1], f[1], g[1]} = four_and_model(int'({d[1], c[1], b[1], a[1]}), fault);

    four_and_sweeper #(.HOLD_CYCLES(4)) u_dut4 (
        .clk (clk), .rst (rst_t[0]), .start (start_t[0]),
        .e (e[0]), .f (f[0]), .g (g[0]),
        .a (a[0]), .b (b[0]), .c (c[0]), .d (d[0]),
        .busy (busy[0]), .done (done[0]), .pass (pass[0]),
        .err_cnt (err[0]), .fail_vec (fv[0])
    );

    four_and_sweeper #(.HOLD_CYCLES(2)) u_dut2 (
        .clk (clk), .rst (rst_t[1]), .start (start_t[1]),
        .e (e[1]), .f (f[1]), .g (g[1]),
        .a (a[1]), .b (b[1]), .c (c[1]), .d (d[1]),
        .busy (busy[1]), .done (done[1]), .pass (pass[1]),
        .err_cnt (err[1]), .fail_vec (fv[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_step(input int i);
        int h;
        h = hold_of(i);
        if (rst_t[i]) begin
            m_phase[i] = 0;
            m_t[i]     = 0;
        end else if (m_phase[i] == 1) begin
            if (m_t[i] == 16 * h - 1) m_phase[i] = 2;
            else m_t[i]++;
        end else if (start_t[i]) begin
            m_phase[i] = 1;
            m_t[i]     = 0;
            m_flt[i]   = fault;
        end
    endtask

    task automatic model_compare(input int i);
        int v, ev, eb, ed, ee, ef;
        if (rst_t[i] || m_phase[i] == 0) begin
            ev = 0; eb = 0; ed = 0; ee = 0; ef = 0;
            check($sformatf("u%0d_pass_idle", i), int'(pass[i]), 0);
        end else if (m_phase[i] == 1) begin
            v  = m_t[i] / hold_of(i);
            ev = v; eb = 1; ed = 0;
            ee = exp_err(v, m_flt[i]);
            ef = exp_fail(v, m_flt[i]);
        end else begin
            ev = 15; eb = 0; ed = 1;
            ee = exp_err(16, m_flt[i]);
            ef = exp_fail(16, m_flt[i]);
            check($sformatf("u%0d_pass", i), int'(pass[i]), (ee == 0) ? 1 : 0);
        end
        check($sformatf("u%0d_abcd", i), int'({d[i], c[i], b[i], a[i]}), ev);
        check($sformatf("u%0d_busy", i), int'(busy[i]), eb);
        check($sformatf("u%0d_done", i), int'(done[i]), ed);
        check($sformatf("u%0d_err_cnt", i), int'(err[i]), ee);
        check($sformatf("u%0d_fail_vec", i), int'(fv[i]), ef);
    endtask

    // Runs one sweep on the HOLD_CYCLES=4 instance; optional extra start
    // pulse when the busy count reaches restart_at.
    task automatic sweep4(input int restart_at, output int nbusy);
        nbusy = 0;
        start_t[0] = 1'b1;
        tick();
        start_t[0] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy[0]) nbusy++;
            start_t[0] = (restart_at > 0 && nbusy == restart_at && busy[0]);
            if (done[0]) break;
        end
        start_t[0] = 1'b0;
        check("sweep4_reached_done", int'(done[0]), 1);
    endtask

    initial begin
        int nb, ph, b1, gap, b2, gap_done;
        rst_t   = 2'b11;
        start_t = 2'b00;
        m_phase = '{0, 0};
        m_t     = '{0, 0};
        m_flt   = '{0, 0};

        fork
            forever begin
                @(posedge clk);
                model_step(0);
                model_step(1);
                @(negedge clk);
                model_compare(0);
                model_compare(1);
            end
        join_none

        // Reset values
        @(negedge clk);
        check("rst_abcd", int'({d[0], c[0], b[0], a[0]}), 0);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_done", int'(done[0]), 0);
        check("rst_pass", int'(pass[0]), 0);
        check("rst_err", int'(err[0]), 0);
        check("rst_fail_vec", int'(fv[0]), 0);
        tick();
        tick();
        rst_t = 2'b00;
        repeat (7) tick();

        // Clean sweep
        fault = 0;
        sweep4(0, nb);
        check("good_busy_len", nb, 64);
        check("good_pass", int'(pass[0]), 1);
        check("good_err", int'(err[0]), 0);
        check("good_fail_vec", int'(fv[0]), 0);
        check("good_abcd_final", int'({d[0], c[0], b[0], a[0]}), 15);
        repeat (3) tick();

        // g stuck at 0
        fault = 1;
        sweep4(0, nb);
        check("g0_err", int'(err[0]), 1);
        check("g0_fail_vec", int'(fv[0]), 15);
        check("g0_pass", int'(pass[0]), 0);
        repeat (3) tick();

        // e = a|b
        fault = 2;
        sweep4(0, nb);
        check("eor_err", int'(err[0]), 8);
        check("eor_fail_vec", int'(fv[0]), 1);
        check("eor_pass", int'(pass[0]), 0);
        repeat (3) tick();

        // start during RUN (vector 7) is ignored
        fault = 0;
        sweep4(7 * 4 + 1, nb);
        check("ign_busy_len", nb, 64);
        check("ign_pass", int'(pass[0]), 1);
        check("ign_err", int'(err[0]), 0);
        repeat (3) tick();

        // Reset mid-RUN at vector 9 with e = a|b fault active
        fault = 2;
        start_t[0] = 1'b1;
        tick();
        start_t[0] = 1'b0;
        nb = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy[0]) nb++;
            if (nb == 9 * 4 + 1) break;
        end
        check("mid_abcd", int'({d[0], c[0], b[0], a[0]}), 9);
        check("mid_err", int'(err[0]), 4);
        check("mid_fail_vec", int'(fv[0]), 1);
        #2 rst_t[0] = 1'b1;
        #1;
        check("arst_busy", int'(busy[0]), 0);
        check("arst_abcd", int'({d[0], c[0], b[0], a[0]}), 0);
        check("arst_err", int'(err[0]), 0);
        check("arst_fail_vec", int'(fv[0]), 0);
        check("arst_done", int'(done[0]), 0);
        tick();
        tick();
        rst_t[0] = 1'b0;
        fault = 0;
        repeat (2) tick();
        sweep4(0, nb);
        check("post_rst_busy_len", nb, 64);
        check("post_rst_pass", int'(pass[0]), 1);
        repeat (3) tick();

        // HOLD_CYCLES=2 with start held high: back-to-back sweeps
        start_t[1] = 1'b1;
        ph = 0; b1 = 0; gap = 0; b2 = 0; gap_done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            case (ph)
                0: if (busy[1]) begin b1 = 1; ph = 1; end
                1: if (busy[1]) b1++;
                   else begin gap = 1; gap_done = int'(done[1]); ph = 2; end
                2: if (busy[1]) begin b2 = 1; ph = 3; end
                   else gap++;
                3: if (busy[1]) b2++;
                   else ph = 4;
                default: ;
            endcase
            if (ph == 4) break;
        end
        check("h2_complete", ph, 4);
        check("h2_first_len", b1, 32);
        check("h2_done_gap", gap, 1);
        check("h2_gap_done", gap_done, 1);
        check("h2_second_len", b2, 32);
        start_t[1] = 1'b0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
